// File: rtl/cei_mochila_pkg.sv
// Cluster-level types and constants for the TMR lockstep return path.
//   tmr_drain_state_e   : RUN / DRAIN / HALT states of the response distributor
//   TMR_MAX_OUTSTANDING : default bound on voted transactions in flight
package cei_mochila_pkg;

  typedef enum logic [1:0] {
    TMR_RUN,
    TMR_DRAIN,
    TMR_HALT
  } tmr_drain_state_e;

  localparam int unsigned TMR_MAX_OUTSTANDING = 4;

endpackage

// File: rtl/obi_pkg.sv
// OBI bus request/response types shared by the cluster return-path logic.
//   obi_req_t  : req, we, be, addr, wdata
//   obi_resp_t : gnt, rvalid, rdata
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/tmr_outstanding_cnt.sv
// Up/down saturating counter of in-flight voted transactions.
//   clk, rst     : clock, synchronous active-high reset
//   inc          : qualified grant (counted transaction)
//   dec          : response returned
//   grant_raw    : bus grant regardless of blocking, used only for overflow detect
//   count        : registered in-flight count
//   count_next   : value count takes at the next edge
//   underflow    : response with nothing in flight (this cycle)
//   overflow     : bus grant while already at the bound (this cycle)
module tmr_outstanding_cnt #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             grant_raw,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_next,
  output logic             underflow,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTSTANDING);

  always_comb begin
    count_next = count;
    if (inc && !dec && (count != MAX_C)) begin
      count_next = count + CNT_W'(1);
    end else if (dec && !inc && (count != '0)) begin
      count_next = count - CNT_W'(1);
    end
  end

  // At the bound the requester is blocked, so a qualified inc cannot fire;
  // any bus grant that still arrives there is the overflow condition.
  assign underflow = dec & (count == '0);
  assign overflow  = grant_raw & (count == MAX_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/tmr_resp_distributor.sv
// Return path of the TMR lockstep cluster: fans one OBI response stream out to
// NHARTS redundant cores, tracks outstanding voted transactions, latches a mask
// of faulty harts and, on a voter error, blocks new grants, drains in-flight
// responses and halts until a software resync.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   voted_req_i    : voted request as driven to the bus (req used)
//   bus_resp_i     : bus response (gnt, rvalid, rdata)
//   core_resp_o    : per-hart response
//   enable_i       : TMR mode active; 0 = pure fan-out, FSM held in RUN
//   error_id_i     : per-hart mismatch flags from the request voter
//   resync_i       : single-cycle pulse leaving HALT
//   block_req_o    : integration must force the voted request low
//   fault_mask_o   : latched faulty harts
//   outstanding_o  : current in-flight count
//   drain_done_o   : high while in HALT
//   proto_err_o    : sticky protocol error (underflow or overflow)
module tmr_resp_distributor
  import obi_pkg::*;
  import cei_mochila_pkg::*;
#(
  parameter int unsigned NHARTS          = 3,
  parameter int unsigned MAX_OUTSTANDING = TMR_MAX_OUTSTANDING,
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  obi_req_t                voted_req_i,
  input  obi_resp_t               bus_resp_i,
  output obi_resp_t [NHARTS-1:0]  core_resp_o,
  input  logic                    enable_i,
  input  logic [NHARTS-1:0]       error_id_i,
  input  logic                    resync_i,
  output logic                    block_req_o,
  output logic [NHARTS-1:0]       fault_mask_o,
  output logic [CNT_W-1:0]        outstanding_o,
  output logic                    drain_done_o,
  output logic                    proto_err_o
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTSTANDING);

  tmr_drain_state_e  state_q, state_d;
  logic [NHARTS-1:0] mask_d;
  logic [CNT_W-1:0]  count_next;
  logic              grant_raw;
  logic              inc;
  logic              underflow;
  logic              overflow;

  // Only req is consumed; the rest of the request travels to the bus untouched.
  logic unused_req_fields;
  assign unused_req_fields = ^{voted_req_i.we, voted_req_i.be,
                               voted_req_i.addr, voted_req_i.wdata};

  // Blocking depends on registered state only, so no input-to-output path.
  assign block_req_o  = (state_q != TMR_RUN) | (outstanding_o == MAX_C);
  assign drain_done_o = (state_q == TMR_HALT);

  assign grant_raw = voted_req_i.req & bus_resp_i.gnt;
  assign inc       = grant_raw & ~block_req_o;

  tmr_outstanding_cnt #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_W           (CNT_W)
  ) u_cnt (
    .clk        (clk_i),
    .rst        (rst_i),
    .inc        (inc),
    .dec        (bus_resp_i.rvalid),
    .grant_raw  (grant_raw),
    .count      (outstanding_o),
    .count_next (count_next),
    .underflow  (underflow),
    .overflow   (overflow)
  );

  always_comb begin
    state_d = state_q;
    mask_d  = fault_mask_o;
    if (!enable_i) begin
      state_d = TMR_RUN;
      mask_d  = '0;
    end else begin
      unique case (state_q)
        TMR_RUN: begin
          if (|error_id_i) begin
            state_d = TMR_DRAIN;
            mask_d  = fault_mask_o | error_id_i;
          end
        end
        TMR_DRAIN: begin
          mask_d = fault_mask_o | error_id_i;
          // Looks at the post-edge count so HALT coincides with the last response.
          if (count_next == '0) begin
            state_d = TMR_HALT;
          end
        end
        TMR_HALT: begin
          if (resync_i) begin
            state_d = TMR_RUN;
            mask_d  = '0;
          end else begin
            mask_d = fault_mask_o | error_id_i;
          end
        end
        default: begin
          state_d = TMR_RUN;
          mask_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= TMR_RUN;
      fault_mask_o <= '0;
      proto_err_o  <= 1'b0;
    end else begin
      state_q      <= state_d;
      fault_mask_o <= mask_d;
      if (underflow || overflow) begin
        proto_err_o <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NHARTS; i++) begin : g_fanout
    assign core_resp_o[i].rdata  = bus_resp_i.rdata;
    assign core_resp_o[i].gnt    = bus_resp_i.gnt & voted_req_i.req
                                   & ~block_req_o & ~fault_mask_o[i];
    assign core_resp_o[i].rvalid = bus_resp_i.rvalid & ~fault_mask_o[i];
  end

endmodule
